// File: rtl/chameleon_pkg.sv
// Shared types and helpers for the classifier back-end (argmax) and PE array masking.
package chameleon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        FLUSH,
        DONE
    } argmax_state_t;

    // Sign-extended most negative value of a signed field 'width' bits wide;
    // callers keep the low 'width' bits (1 followed by zeros).
    function automatic logic [63:0] most_negative(input int width);
        return ~((64'd1 << (width - 1)) - 64'd1);
    endfunction

endpackage

// File: rtl/argmax_tree.sv
// Combinational COLS-way signed maximum; the lowest column wins on ties.
module argmax_tree
    import chameleon_pkg::*;
#(
    parameter  int COLS = 16,
    parameter  int W    = 24,
    localparam int IW   = $clog2(COLS)
) (
    input  logic signed [W-1:0]  values [COLS],
    output logic signed [W-1:0]  max_value,
    output logic        [IW-1:0] max_index
);

    localparam int              LEAVES = 1 << IW;
    localparam logic [63:0]     S64    = most_negative(W);
    localparam logic signed [W-1:0] SENT = S64[W-1:0];

    // Heap-ordered balanced tree: node n has children 2n (lower columns) and 2n+1.
    // Padding leaves sit to the right, so they can never beat a real column on a tie.
    always_comb begin : tree
        logic signed [W-1:0]  node_v [2*LEAVES];
        logic        [IW-1:0] node_i [2*LEAVES];
        for (int n = 0; n < 2*LEAVES; n++) begin
            node_v[n] = SENT;
            node_i[n] = '0;
        end
        for (int c = 0; c < COLS; c++) begin
            node_v[LEAVES+c] = values[c];
            node_i[LEAVES+c] = IW'(c);
        end
        for (int n = LEAVES - 1; n >= 1; n--) begin
            if (node_v[2*n+1] > node_v[2*n]) begin
                node_v[n] = node_v[2*n+1];
                node_i[n] = node_i[2*n+1];
            end else begin
                node_v[n] = node_v[2*n];
                node_i[n] = node_i[2*n];
            end
        end
        max_value = node_v[1];
        max_index = node_i[1];
    end

endmodule

// File: rtl/argmax_unit.sv
// Streams tiles of column accumulators and reports the global argmax class and its value.
module argmax_unit
    import chameleon_pkg::*;
#(
    parameter  int COLS                   = 16,
    parameter  int ACCUMULATION_BIT_WIDTH = 24,
    parameter  int MAX_TILES              = 16,
    localparam int ClassIndexBitWidth     = $clog2(COLS*MAX_TILES)
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     start,
    input  logic        [$clog2(MAX_TILES)-1:0]      num_tiles_minus_one,
    input  logic                                     tile_valid,
    output logic                                     tile_ready,
    input  logic signed [ACCUMULATION_BIT_WIDTH-1:0] col_accumulator [COLS],
    output logic                                     busy,
    output logic                                     done,
    output logic        [ClassIndexBitWidth-1:0]     class_index,
    output logic signed [ACCUMULATION_BIT_WIDTH-1:0] max_value
);

    localparam int TW   = $clog2(MAX_TILES);
    localparam int CW   = $clog2(COLS);
    localparam int AW   = ACCUMULATION_BIT_WIDTH;
    localparam int CIW  = ClassIndexBitWidth;
    localparam logic [63:0]          S64  = most_negative(AW);
    localparam logic signed [AW-1:0] SENT = S64[AW-1:0];

    argmax_state_t          state_q, state_d;
    logic [TW-1:0]          ntiles_q, ntiles_d;
    logic [TW-1:0]          tile_cnt_q, tile_cnt_d;
    logic                   s1_valid_q, s1_valid_d;
    logic signed [AW-1:0]   s1_data_q [COLS];
    logic signed [AW-1:0]   s1_data_d [COLS];
    logic [TW-1:0]          s1_tile_q, s1_tile_d;
    logic signed [AW-1:0]   best_value_q, best_value_d;
    logic [CIW-1:0]         best_index_q, best_index_d;
    logic [CIW-1:0]         class_index_q, class_index_d;
    logic signed [AW-1:0]   max_value_q, max_value_d;
    logic                   busy_q, busy_d;
    logic                   tile_ready_q, tile_ready_d;
    logic                   done_q, done_d;

    logic signed [AW-1:0]   tree_value;
    logic [CW-1:0]          tree_col;
    logic [CIW-1:0]         tree_global;
    logic signed [AW-1:0]   merge_value;
    logic [CIW-1:0]         merge_index;
    logic                   accept;

    argmax_tree #(
        .COLS (COLS),
        .W    (AW)
    ) u_tree (
        .values    (s1_data_q),
        .max_value (tree_value),
        .max_index (tree_col)
    );

    assign accept      = tile_ready_q & tile_valid;
    assign tree_global = CIW'(s1_tile_q) * CIW'(COLS) + CIW'(tree_col);

    // Strictly greater: an equal value from a later tile keeps the earlier, lower index.
    always_comb begin
        merge_value = best_value_q;
        merge_index = best_index_q;
        if (s1_valid_q && (tree_value > best_value_q)) begin
            merge_value = tree_value;
            merge_index = tree_global;
        end
    end

    always_comb begin
        state_d       = state_q;
        ntiles_d      = ntiles_q;
        tile_cnt_d    = tile_cnt_q;
        s1_valid_d    = accept;
        s1_data_d     = s1_data_q;
        s1_tile_d     = s1_tile_q;
        best_value_d  = merge_value;
        best_index_d  = merge_index;
        class_index_d = class_index_q;
        max_value_d   = max_value_q;

        if (accept) begin
            s1_data_d = col_accumulator;
            s1_tile_d = tile_cnt_q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = COLLECT;
                    ntiles_d     = num_tiles_minus_one;
                    tile_cnt_d   = '0;
                    best_value_d = SENT;
                    best_index_d = '0;
                end
            end
            COLLECT: begin
                if (accept) begin
                    tile_cnt_d = tile_cnt_q + TW'(1);
                    if (tile_cnt_q == ntiles_q) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                state_d       = DONE;
                class_index_d = merge_index;
                max_value_d   = merge_value;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        tile_ready_d = (state_d == COLLECT);
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ntiles_q      <= '0;
            tile_cnt_q    <= '0;
            s1_valid_q    <= 1'b0;
            s1_data_q     <= '{default: '0};
            s1_tile_q     <= '0;
            best_value_q  <= SENT;
            best_index_q  <= '0;
            class_index_q <= '0;
            max_value_q   <= '0;
            busy_q        <= 1'b0;
            tile_ready_q  <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ntiles_q      <= ntiles_d;
            tile_cnt_q    <= tile_cnt_d;
            s1_valid_q    <= s1_valid_d;
            s1_data_q     <= s1_data_d;
            s1_tile_q     <= s1_tile_d;
            best_value_q  <= best_value_d;
            best_index_q  <= best_index_d;
            class_index_q <= class_index_d;
            max_value_q   <= max_value_d;
            busy_q        <= busy_d;
            tile_ready_q  <= tile_ready_d;
            done_q        <= done_d;
        end
    end

    assign tile_ready  = tile_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign class_index = class_index_q;
    assign max_value   = max_value_q;

endmodule
